// File: rtl/arinc429_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arinc429_pkg
//  Description : Shared ARINC 429 constants, rate encoding and helpers used
//                by both the transmitter and the receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package arinc429_pkg;

    // System clock and line rates, Hz and bit/s
    localparam int FCLK     = 50_000_000;
    localparam int V1MB     = 1_000_000;
    localparam int V100KB   = 100_000;
    localparam int V50KB    = 50_000;
    localparam int V12_5KB  = 12_500;

    // Nvel rate-select encoding
    localparam logic [1:0] NVEL_1MB    = 2'd3;
    localparam logic [1:0] NVEL_100KB  = 2'd2;
    localparam logic [1:0] NVEL_50KB   = 2'd1;
    localparam logic [1:0] NVEL_12_5KB = 2'd0;

    // Word layout
    localparam int LBL_W    = 8;
    localparam int DAT_W    = 23;
    localparam int WORD_LEN = 32;
    localparam int GAP_BITS = 4;

    // Timer width: must hold 4 half-bits at the slowest rate (8000)
    localparam int CNT_W    = 13;

    // Receiver FSM encoding
    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_RX    = 2'd2;

    // Half a bit period in system clocks for the selected rate
    function automatic logic [CNT_W-1:0] ar_nt(input logic [1:0] nvel);
        case (nvel)
            NVEL_1MB:   ar_nt = CNT_W'(FCLK / (2 * V1MB));
            NVEL_100KB: ar_nt = CNT_W'(FCLK / (2 * V100KB));
            NVEL_50KB:  ar_nt = CNT_W'(FCLK / (2 * V50KB));
            default:    ar_nt = CNT_W'(FCLK / (2 * V12_5KB));
        endcase
    endfunction

    // Parity bit that makes label + data + parity contain an odd number of ones
    function automatic logic odd_par(input logic [LBL_W+DAT_W-1:0] bits);
        odd_par = ~(^bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ar_rx_line.sv
`default_nettype none
// ============================================================================
//  Module      : ar_rx_line
//  Description : ARINC 429 line front end: synchronizers, pulse glitch
//                filter with null re-arm, conflict detect and idle timer.
//                All outputs are single-cycle strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module ar_rx_line
    import arinc429_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] nvel,
    input  logic       rxd1,
    input  logic       rxd0,
    output logic       bit_ok,
    output logic       bit_val,
    output logic       conflict,
    output logic       gap
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       r_sync1;      // {rxd1, rxd0} first stage
    logic [1:0]       r_sync2;      // {rxd1, rxd0} synchronized line state
    logic [1:0]       r_prev;       // line state seen on the previous clock
    logic [CNT_W-1:0] r_flt_cnt;    // clocks the current line state has held
    logic [CNT_W-1:0] r_idle_cnt;   // clocks of continuous null state
    logic             r_armed;      // a null has been seen since the last accept

    logic [CNT_W-1:0] w_nt;
    logic [CNT_W-1:0] w_t_flt;
    logic [CNT_W-1:0] w_t_gap;
    logic [CNT_W-1:0] w_flt_next;
    logic [CNT_W-1:0] w_idle_next;
    logic             w_hit;
    logic             w_pulse;

    // Filter and idle thresholds, next counter values and event strobes
    always_comb begin
        w_nt    = ar_nt(nvel);
        w_t_flt = w_nt >> 1;
        w_t_gap = w_nt << 2;

        // A change of line state restarts the stability count at 1
        if (r_sync2 != r_prev)
            w_flt_next = CNT_W'(1);
        else if (r_flt_cnt == CNT_MAX)
            w_flt_next = r_flt_cnt;
        else
            w_flt_next = r_flt_cnt + CNT_W'(1);

        if (r_sync2 != 2'b00)
            w_idle_next = '0;
        else if (r_idle_cnt == CNT_MAX)
            w_idle_next = r_idle_cnt;
        else
            w_idle_next = r_idle_cnt + CNT_W'(1);

        // Equality makes each held state fire exactly once
        w_hit    = (w_flt_next == w_t_flt);
        w_pulse  = (r_sync2 == 2'b10) || (r_sync2 == 2'b01);
        bit_ok   = w_hit && w_pulse && r_armed;
        bit_val  = r_sync2[1];
        conflict = w_hit && (r_sync2 == 2'b11);
        gap      = (w_idle_next == w_t_gap);
    end

    // Synchronizers, counters and the null re-arm flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 2'b00;
            r_sync2    <= 2'b00;
            r_prev     <= 2'b00;
            r_flt_cnt  <= '0;
            r_idle_cnt <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_sync1    <= {rxd1, rxd0};
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_flt_cnt  <= w_flt_next;
            r_idle_cnt <= w_idle_next;
            if (r_sync2 == 2'b00)
                r_armed <= 1'b1;
            else if (bit_ok)
                r_armed <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ar_rxd.sv
`default_nettype none
// ============================================================================
//  Module      : ar_rxd
//  Description : ARINC 429 receiver. Recovers 32-bit words (label MSB first,
//                data LSB first, odd parity) and strobes good words, parity
//                errors and framing errors to the host side.
//  Revision    : 1.0  initial release
// ============================================================================
module ar_rxd
    import arinc429_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Nvel,
    input  logic        RXD1,
    input  logic        RXD0,
    output logic [7:0]  ADR,
    output logic [22:0] DAT,
    output logic        ce_wr,
    output logic        err_par,
    output logic        err_frm,
    output logic        en_rx,
    output logic [5:0]  cb_bit
);

    logic             w_bit_ok;
    logic             w_bit_val;
    logic             w_conflict;
    logic             w_gap;
    logic             w_word_ok;

    logic [1:0]       r_state;
    logic [LBL_W-1:0] r_lbl;
    logic [DAT_W-1:0] r_dat;

    ar_rx_line u_line (
        .clk      (clk),
        .rst      (rst),
        .nvel     (Nvel),
        .rxd1     (RXD1),
        .rxd0     (RXD0),
        .bit_ok   (w_bit_ok),
        .bit_val  (w_bit_val),
        .conflict (w_conflict),
        .gap      (w_gap)
    );

    // The incoming bit is the parity bit when the word is being closed
    always_comb begin
        w_word_ok = (w_bit_val == odd_par({r_lbl, r_dat}));
    end

    // Word FSM, shift registers and registered host outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HUNT;
            r_lbl   <= '0;
            r_dat   <= '0;
            ADR     <= '0;
            DAT     <= '0;
            ce_wr   <= 1'b0;
            err_par <= 1'b0;
            err_frm <= 1'b0;
            en_rx   <= 1'b0;
            cb_bit  <= '0;
        end else begin
            ce_wr   <= 1'b0;
            err_par <= 1'b0;
            err_frm <= 1'b0;
            if (w_conflict) begin
                // Only a word in flight is reported; cb_bit otherwise keeps
                // the count of the last completed word
                if (r_state == ST_RX) begin
                    err_frm <= 1'b1;
                    cb_bit  <= '0;
                end
                r_state <= ST_HUNT;
                en_rx   <= 1'b0;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_gap)
                            r_state <= ST_READY;
                    end
                    ST_READY: begin
                        if (w_bit_ok) begin
                            r_state <= ST_RX;
                            en_rx   <= 1'b1;
                            cb_bit  <= 6'd1;
                            r_lbl   <= {r_lbl[LBL_W-2:0], w_bit_val};
                        end
                    end
                    ST_RX: begin
                        if (w_gap) begin
                            err_frm <= 1'b1;
                            r_state <= ST_READY;
                            en_rx   <= 1'b0;
                            cb_bit  <= '0;
                        end else if (w_bit_ok) begin
                            cb_bit <= cb_bit + 6'd1;
                            if (cb_bit < 6'(LBL_W)) begin
                                r_lbl <= {r_lbl[LBL_W-2:0], w_bit_val};
                            end else if (cb_bit < 6'(WORD_LEN - 1)) begin
                                r_dat <= {w_bit_val, r_dat[DAT_W-1:1]};
                            end else begin
                                if (w_word_ok) begin
                                    ADR   <= r_lbl;
                                    DAT   <= r_dat;
                                    ce_wr <= 1'b1;
                                end else begin
                                    err_par <= 1'b1;
                                end
                                r_state <= ST_HUNT;
                                en_rx   <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_HUNT;
                        en_rx   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
